// File: rtl/ksa_bist_ctrl.sv
// BIST controller for the 16-bit Kogge-Stone adder: directed then LFSR vectors, one-edge compare.
// Latency: done rises 6+NUM_RANDOM cycles after an accepted start; start ignored while busy.
module ksa_bist_ctrl #(
    parameter int          NUM_RANDOM = 256,
    parameter logic [31:0] SEED       = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] dut_a,
    output logic [15:0] dut_b,
    output logic        dut_cin,
    input  logic [15:0] dut_s,
    input  logic        dut_cout,
    output logic [15:0] fail_a,
    output logic [15:0] fail_b,
    output logic        fail_cin,
    output logic        fail_valid
);

    localparam int          TOTAL      = 6 + NUM_RANDOM;
    localparam logic [16:0] LAST_IDX   = 17'(TOTAL - 1);
    localparam logic [16:0] NUM_DIR    = 17'd6;
    localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [16:0] idx;
    logic [31:0] lfsr;

    logic [16:0] expected;
    logic        mismatch;
    logic [16:0] nxt_idx;
    logic [15:0] nxt_a;
    logic [15:0] nxt_b;
    logic        nxt_cin;
    logic        nxt_is_rand;

    // Packed as {cin, b, a}.
    function automatic logic [32:0] directed_vec(input logic [2:0] i);
        logic [32:0] v;
        case (i)
            3'd0:    v = {1'b0, 16'h0000, 16'h0000};
            3'd1:    v = {1'b0, 16'h0001, 16'hFFFF};
            3'd2:    v = {1'b1, 16'h5678, 16'h1234};
            3'd3:    v = {1'b0, 16'h5555, 16'hAAAA};
            3'd4:    v = {1'b1, 16'hFFFF, 16'hFFFF};
            3'd5:    v = {1'b0, 16'h8000, 16'h8000};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0);
    endfunction

    assign expected = {1'b0, dut_a} + {1'b0, dut_b} + {16'b0, dut_cin};
    assign mismatch = ({dut_cout, dut_s} != expected);
    assign pass     = done && (err_count == 16'h0);

    always_comb begin
        nxt_idx     = idx + 17'd1;
        nxt_is_rand = (nxt_idx >= NUM_DIR);
        nxt_a       = '0;
        nxt_b       = '0;
        nxt_cin     = 1'b0;
        if (nxt_is_rand) begin
            nxt_a   = lfsr[15:0];
            nxt_b   = lfsr[31:16];
            nxt_cin = lfsr[31] ^ lfsr[0];
        end else begin
            {nxt_cin, nxt_b, nxt_a} = directed_vec(nxt_idx[2:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            lfsr       <= SEED_EFF;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            dut_a      <= '0;
            dut_b      <= '0;
            dut_cin    <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        idx        <= '0;
                        lfsr       <= SEED_EFF;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err_count  <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cin   <= 1'b0;
                        fail_valid <= 1'b0;
                        {dut_cin, dut_b, dut_a} <= directed_vec(3'd0);
                    end
                end
                RUN: begin
                    // The vector on dut_* was registered last edge; its sum is settled now.
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (!fail_valid) begin
                            fail_a     <= dut_a;
                            fail_b     <= dut_b;
                            fail_cin   <= dut_cin;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx     <= nxt_idx;
                        dut_a   <= nxt_a;
                        dut_b   <= nxt_b;
                        dut_cin <= nxt_cin;
                        if (nxt_is_rand) begin
                            lfsr <= lfsr_step(lfsr);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_bist_ctrl.sv
// Bench for ksa_bist_ctrl: behavioural adder with injectable faults, scoreboard of expected vectors.
module tb_ksa_bist_ctrl;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    int          sel = 0;
    int          fmode = 0;

    logic        busy [3];
    logic        done [3];
    logic        pass [3];
    logic [15:0] err  [3];
    logic [15:0] da   [3];
    logic [15:0] db   [3];
    logic        dcin [3];
    logic [15:0] ds   [3];
    logic        dco  [3];
    logic [15:0] fa   [3];
    logic [15:0] fb   [3];
    logic        fcin [3];
    logic        fv   [3];
    logic        st   [3];

    int   n_assert = 0;
    int   n_fail = 0;
    vec_t q[$];
    int   exp_err;

    always #5 clk = ~clk;

    // Adder model; fmode 1 forces s[0] high, fmode 2 inverts carry-out.
    always_comb begin
        logic [16:0] t;
        t = '0;
        for (int i = 0; i < 3; i++) begin
            t      = {1'b0, da[i]} + {1'b0, db[i]} + {16'b0, dcin[i]};
            ds[i]  = t[15:0] | {15'b0, (fmode == 1)};
            dco[i] = t[16] ^ (fmode == 2);
            st[i]  = start && (sel == i);
        end
    end

    ksa_bist_ctrl #(.NUM_RANDOM(256)) u_main (
        .clk(clk), .rst(rst), .start(st[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .dut_a(da[0]), .dut_b(db[0]), .dut_cin(dcin[0]), .dut_s(ds[0]),
        .dut_cout(dco[0]), .fail_a(fa[0]), .fail_b(fb[0]), .fail_cin(fcin[0]), .fail_valid(fv[0])
    );

    ksa_bist_ctrl #(.NUM_RANDOM(10)) u_small (
        .clk(clk), .rst(rst), .start(st[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .dut_a(da[1]), .dut_b(db[1]), .dut_cin(dcin[1]), .dut_s(ds[1]),
        .dut_cout(dco[1]), .fail_a(fa[1]), .fail_b(fb[1]), .fail_cin(fcin[1]), .fail_valid(fv[1])
    );

    ksa_bist_ctrl #(.NUM_RANDOM(4), .SEED(32'h0)) u_seed0 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err[2]), .dut_a(da[2]), .dut_b(db[2]), .dut_cin(dcin[2]), .dut_s(ds[2]),
        .dut_cout(dco[2]), .fail_a(fa[2]), .fail_b(fb[2]), .fail_cin(fcin[2]), .fail_valid(fv[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t dir_vec(input int i);
        vec_t v;
        case (i)
            0:       v = '{a: 16'h0000, b: 16'h0000, cin: 1'b0};
            1:       v = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0};
            2:       v = '{a: 16'h1234, b: 16'h5678, cin: 1'b1};
            3:       v = '{a: 16'hAAAA, b: 16'h5555, cin: 1'b0};
            4:       v = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1};
            default: v = '{a: 16'h8000, b: 16'h8000, cin: 1'b0};
        endcase
        return v;
    endfunction

    // Fills the scoreboard and works out how many vectors the injected fault will break.
    task automatic push_run(input int total, input logic [31:0] seed, input int fm);
        logic [31:0] l;
        logic [16:0] s;
        vec_t        v;
        l = (seed == 32'h0) ? 32'h1 : seed;
        q.delete();
        exp_err = 0;
        for (int i = 0; i < total; i++) begin
            if (i < 6) begin
                v = dir_vec(i);
            end else begin
                v.a   = l[15:0];
                v.b   = l[31:16];
                v.cin = l[31] ^ l[0];
                l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
            end
            s = {1'b0, v.a} + {1'b0, v.b} + {16'b0, v.cin};
            if (fm == 2 || (fm == 1 && s[0] == 1'b0)) exp_err++;
            q.push_back(v);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy[sel]), 0);
        chk({tag, "_done"}, 32'(done[sel]), 0);
        chk({tag, "_pass"}, 32'(pass[sel]), 0);
        chk({tag, "_err"}, 32'(err[sel]), 0);
        chk({tag, "_dut_vec"}, {da[sel], db[sel]}, 0);
        chk({tag, "_dut_cin"}, 32'(dcin[sel]), 0);
        chk({tag, "_fail_vec"}, {fa[sel], fb[sel]}, 0);
        chk({tag, "_fail_cin"}, 32'(fcin[sel]), 0);
        chk({tag, "_fail_valid"}, 32'(fv[sel]), 0);
    endtask

    // Starts a run, pops one expected vector per cycle, optionally pulses start mid-run and on the last edge.
    task automatic do_run(input string tag, input int total, input logic [31:0] seed, input int fm,
                          input int midstart, input bit endstart);
        vec_t v;
        int   bcyc;
        push_run(total, seed, fm);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_cleared_err"}, 32'(err[sel]), 0);
        chk({tag, "_cleared_fv"}, 32'(fv[sel]), 0);
        chk({tag, "_cleared_done"}, 32'(done[sel]), 0);
        bcyc = 0;
        for (int k = 0; k < total; k++) begin
            v = q.pop_front();
            chk($sformatf("%s_vec%0d", tag, k), {da[sel], db[sel]}, {v.a, v.b});
            chk($sformatf("%s_cin%0d", tag, k), 32'(dcin[sel]), 32'(v.cin));
            if (fm == 0 && k == 2) chk({tag, "_sum_v2"}, {15'b0, dco[sel], ds[sel]}, 32'h0000_68AD);
            if (busy[sel]) bcyc++;
            if (k == midstart) start = 1'b1;
            if (k == midstart + 1) start = 1'b0;
            if (endstart && k == total - 1) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(bcyc), 32'(total));
        chk({tag, "_busy_end"}, 32'(busy[sel]), 0);
        chk({tag, "_done"}, 32'(done[sel]), 1);
        chk({tag, "_err"}, 32'(err[sel]), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass[sel]), (exp_err == 0) ? 32'd1 : 32'd0);
        chk({tag, "_fail_valid"}, 32'(fv[sel]), (exp_err == 0) ? 32'd0 : 32'd1);
        chk({tag, "_last_vec"}, {da[sel], db[sel]}, {v.a, v.b});
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        sel = 0; chk_zero("rst_main");
        sel = 1; chk_zero("rst_small");
        sel = 2; chk_zero("rst_seed0");
        @(negedge clk) rst = 1'b0;

        // Clean run with starts pulsed mid-run and on the final compare edge.
        sel = 0; fmode = 0;
        do_run("main", 262, 32'hACE1_1234, 0, 100, 1'b1);
        @(negedge clk);
        chk("main_hold_done", 32'(done[0]), 1);
        chk("main_hold_busy", 32'(busy[0]), 0);
        chk("main_hold_err", 32'(err[0]), 0);

        // Restart with s[0] stuck high: vector 0 must be captured first.
        fmode = 1;
        do_run("s0fault", 262, 32'hACE1_1234, 1, -10, 1'b0);
        chk("s0fault_fail_vec", {fa[0], fb[0]}, 32'h0);
        chk("s0fault_fail_cin", 32'(fcin[0]), 0);
        chk("s0fault_err_nonzero", 32'(err[0] != 16'h0), 1);

        // New start clears the previous errors; reset lands at RUN cycle 4.
        fmode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart_err_clear", 32'(err[0]), 0);
        chk("restart_fv_clear", 32'(fv[0]), 0);
        chk("restart_busy", 32'(busy[0]), 1);
        repeat (3) @(negedge clk);
        chk("prerst_vec3", {da[0], db[0]}, 32'hAAAA_5555);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_busy", 32'(busy[0]), 0);
        do_run("postrst", 262, 32'hACE1_1234, 0, -10, 1'b0);

        // Carry-out inverted on the NUM_RANDOM=10 instance: every vector fails.
        sel = 1; fmode = 2;
        do_run("coutinv", 16, 32'hACE1_1234, 2, -10, 1'b0);
        chk("coutinv_fail_vec", {fa[1], fb[1]}, 32'h0);
        chk("coutinv_fail_cin", 32'(fcin[1]), 0);

        // Zero seed substitutes 1: vector 6 is A=0001, B=0000, Cin=1.
        sel = 2; fmode = 0;
        do_run("seed0", 10, 32'h0, 0, -10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_bist_ctrl.md
Name: ksa_bist_ctrl

Overview:
- Built-in self-test controller for the 16-bit Kogge-Stone adder.
- Drives the adder's A/B/Cin inputs with a fixed directed set followed by LFSR pseudo-random vectors.
- Samples S/Cout one cycle later, compares them against a behavioural reference sum, counts mismatches and captures the first failing vector.
- Sits beside the adder instance; a top-level or bench pulses start and reads done/pass.

Parameters:
- NUM_RANDOM, 256, number of LFSR vectors applied after the directed set; range 0..65535.
- SEED, 32'hACE1_1234, initial LFSR state; a value of 0 is replaced by 32'h0000_0001.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a run; honoured only while not busy.
- busy  output  1  high while vectors are being applied or compared.
- done  output  1  high after a run completes; held until the next accepted start.
- pass  output  1  done && (err_count == 0).
- err_count  output  16  number of mismatching vectors; saturates at 16'hFFFF.
- dut_a  output  16  operand A to the adder.
- dut_b  output  16  operand B to the adder.
- dut_cin  output  1  carry-in to the adder.
- dut_s  input  16  adder sum.
- dut_cout  input  1  adder carry-out.
- fail_a  output  16  A of the first failing vector.
- fail_b  output  16  B of the first failing vector.
- fail_cin  output  1  Cin of the first failing vector.
- fail_valid  output  1  high once a failure has been captured in the current run.

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, pass, err_count, dut_a/b/cin, fail_*, fail_valid. Internal vector index = 0. LFSR = SEED (zero-substituted).
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: go to RUN. On the same edge:
  - clear err_count, fail_*, fail_valid and done;
  - reload the LFSR;
  - register vector 0 onto dut_a/b/cin;
  - set busy.
- Start while in RUN is ignored.
- Total vectors T = 6 + NUM_RANDOM.
- Directed vectors 0..5, as (A, B, Cin):
  - (0000, 0000, 0)
  - (FFFF, 0001, 0)
  - (1234, 5678, 1)
  - (AAAA, 5555, 0)
  - (FFFF, FFFF, 1)
  - (8000, 8000, 0)
- Random vectors 6..T-1:
  - A = lfsr[15:0], B = lfsr[31:16], Cin = lfsr[31] ^ lfsr[0].
  - LFSR is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shifted right once after each random vector is registered.
- Pipeline: the adder is combinational, so each vector is compared one edge after it is driven.
  - At RUN edge k (k = 1..T), compare dut_s/dut_cout against expected = {1'b0,dut_a} + {1'b0,dut_b} + dut_cin (17 bits; bit 16 = Cout).
  - On the same edge, register vector k if k < T.
- Mismatch:
  - err_count increments, saturating at 16'hFFFF.
  - If fail_valid = 0, capture the current dut_a/b/cin into fail_* and set fail_valid.
  - Later mismatches do not overwrite fail_*.
- Edge T (last compare): go to DONE; busy = 0, done = 1. dut_a/b/cin hold the last vector. Latency from the start edge to done is T cycles.
- pass is combinational from done and err_count. It is 0 whenever done = 0.
- NUM_RANDOM = 0: only the 6 directed vectors; done arrives 6 cycles after start.
- Reset mid-run: immediate return to reset values; no partial result is kept.
- Start asserted on the same edge the run finishes (edge T): ignored, because the state is still RUN at that edge.

Test Plan:
- Correct adder attached, NUM_RANDOM=256, one start pulse -> busy for 262 cycles; done=1, pass=1, err_count=0, fail_valid=0. Vector 2 drives 1234/5678/1 and the adder returns 68AD/0.
- dut_s[0] forced to 1 -> vector 0 fails first: fail_a=0000, fail_b=0000, fail_cin=0, fail_valid=1, err_count≥1, pass=0.
- dut_cout inverted, NUM_RANDOM=10 -> all 16 vectors mismatch: err_count=16; fail_* = vector 0; done after 16 cycles.
- Start pulsed again mid-run, and again on the final compare edge -> both ignored, results unchanged. A start after done restarts with err_count cleared and an identical LFSR sequence (same dut_a at vector 6 as the first run).
- rst asserted at RUN cycle 4 -> all outputs 0 asynchronously, state IDLE. A later start completes normally with pass=1.
- SEED=0 -> the LFSR starts from 1: vector 6 drives A=0001, B=0000, Cin=1. The run completes with pass=1.
